// File: rtl/input_demultiplexer_pkg.sv
// Shared types and constants for the pin-side input demultiplexer.
package input_demultiplexer_pkg;

  localparam int DEFAULT_INPUT_WIDTH = 8;
  localparam logic [7:0] BROADCAST_CHANNEL = 8'hFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    ISSUE    = 2'd2,
    WAIT_LOW = 2'd3
  } demux_state_t;

endpackage

// File: rtl/input_demultiplexer_strobe_sync_edge.sv
// Three-flop synchroniser for an asynchronous pin strobe with rising-edge detect.
// level is the synchronised strobe (s2); rise is a one-cycle pulse, two edges after the pin is first sampled high.
module strobe_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic s1, s2, s3;
  logic primed, armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      primed <= 1'b0;
      armed  <= 1'b0;
    end else begin
      s1     <= async_in;
      s2     <= s1;
      s3     <= s2;
      primed <= 1'b1;
      // Arm only once a genuine low has been sampled from the pin, so a strobe
      // already high at reset release does not look like a rising edge.
      if (primed && !s1) armed <= 1'b1;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3 & armed;

endmodule

// File: rtl/input_demultiplexer.sv
// Captures a strobed pin sample and steers it to one of NUM_FILTERS channel registers (valid pulse 3 edges after capture sync).
// Optional broadcast on select 8'hFF is enabled by defining INPUT_DEMUX_BROADCAST_EN.
module input_demultiplexer
  import input_demultiplexer_pkg::*;
#(
  parameter int NUM_FILTERS = 8,
  parameter int INPUT_WIDTH = DEFAULT_INPUT_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [INPUT_WIDTH-1:0]             i_data,
  input  logic                               i_strobe,
  input  logic [7:0]                         i_select_input_channel,
  output logic [NUM_FILTERS*INPUT_WIDTH-1:0] o_channel_data,
  output logic [NUM_FILTERS-1:0]             o_channel_valid,
  output logic                               o_busy,
  output logic                               o_error
);

  demux_state_t           state;
  logic [INPUT_WIDTH-1:0] hold_data;
  logic [7:0]             hold_sel;
  logic [NUM_FILTERS-1:0] write_mask;
  logic                   strobe_level, strobe_rise;

  strobe_sync_edge u_strobe_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (i_strobe),
    .level    (strobe_level),
    .rise     (strobe_rise)
  );

  // An all-zero mask marks an invalid destination.
  always_comb begin
    write_mask = '0;
    for (int k = 0; k < NUM_FILTERS; k++) begin
      write_mask[k] = (hold_sel == 8'(k));
    end
`ifdef INPUT_DEMUX_BROADCAST_EN
    if (hold_sel == BROADCAST_CHANNEL) write_mask = '1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      hold_data       <= '0;
      hold_sel        <= '0;
      o_channel_data  <= '0;
      o_channel_valid <= '0;
      o_busy          <= 1'b0;
      o_error         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (strobe_rise) begin
            hold_data <= i_data;
            hold_sel  <= i_select_input_channel;
            o_busy    <= 1'b1;
            state     <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (|write_mask) begin
            o_channel_valid <= write_mask;
            for (int k = 0; k < NUM_FILTERS; k++) begin
              if (write_mask[k]) o_channel_data[k*INPUT_WIDTH +: INPUT_WIDTH] <= hold_data;
            end
          end else begin
            o_error <= 1'b1;
          end
          state <= ISSUE;
        end
        ISSUE: begin
          o_channel_valid <= '0;
          if (!strobe_level) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            state <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!strobe_level) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_demultiplexer.sv
// Randomised and directed bench for input_demultiplexer against a transaction-level reference model.
module tb_input_demultiplexer;

  localparam int NF = 8;
  localparam int W  = 8;
`ifdef INPUT_DEMUX_BROADCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  data;
  logic          strobe;
  logic [7:0]    sel;
  logic [NF*W-1:0] ch_data;
  logic [NF-1:0] ch_valid;
  logic          busy, error;

  always #5 clk = ~clk;

  input_demultiplexer #(.NUM_FILTERS(NF), .INPUT_WIDTH(W)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .i_data                 (data),
    .i_strobe               (strobe),
    .i_select_input_channel (sel),
    .o_channel_data         (ch_data),
    .o_channel_valid        (ch_valid),
    .o_busy                 (busy),
    .o_error                (error)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int pulse_cnt    = 0;

  // Reference model: pin samples since reset plus one outstanding transaction.
  logic [W-1:0]  m_chan [NF];
  logic          m_err, m_busy;
  logic [NF-1:0] m_valid;
  int            hist[$];
  int            cap_k;
  logic [W-1:0]  m_hold_d;
  logic [7:0]    m_hold_s;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack_model();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < NF; i++) v[i*W +: W] = m_chan[i];
    return v;
  endfunction

  // Rules: a write is recognised two edges after the pin is first seen high
  // following a real low; the channel updates one edge later; the block is
  // released once the pin has been low two edges earlier (no sooner than
  // two edges after the write).
  task automatic model_edge();
    int k;
    m_valid = '0;
    if (rst) begin
      for (int i = 0; i < NF; i++) m_chan[i] = '0;
      m_err  = 1'b0;
      m_busy = 1'b0;
      hist.delete();
      return;
    end
    k = hist.size();
    hist.push_back(int'(strobe));
    if (m_busy) begin
      if (k == cap_k + 1) begin
        if (int'(m_hold_s) < NF) begin
          m_chan[m_hold_s] = m_hold_d;
          m_valid[m_hold_s] = 1'b1;
        end else if (BCAST && m_hold_s == 8'hFF) begin
          for (int i = 0; i < NF; i++) m_chan[i] = m_hold_d;
          m_valid = '1;
        end else begin
          m_err = 1'b1;
        end
      end else if (k >= cap_k + 2 && hist[k-2] == 0) begin
        m_busy = 1'b0;
      end
    end else if (k >= 3 && hist[k-2] == 1 && hist[k-3] == 0) begin
      m_busy   = 1'b1;
      cap_k    = k;
      m_hold_d = data;
      m_hold_s = sel;
    end
  endtask

  task automatic cycle(input logic r, input logic s, input logic [7:0] d, input logic [7:0] c);
    @(negedge clk);
    rst = r; strobe = s; data = d; sel = c;
    @(posedge clk);
    model_edge();
    #1;
    if (ch_valid !== '0) pulse_cnt++;
    check("data",  ch_data,  pack_model());
    check("valid", ch_valid, m_valid);
    check("busy",  busy,     m_busy);
    check("error", error,    m_err);
  endtask

  logic [7:0] glitch_val;
  logic [7:0] vals [NF];
  logic       lvl;
  logic [7:0] rsel;
  int         hold;

  initial begin
    rst = 1'b1; strobe = 1'b0; data = '0; sel = '0;

    // Reset with random pins, then release with the strobe still high.
    cycle(1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
    cycle(1'b1, 1'b1, 8'($urandom), 8'($urandom));
    check("reset_data", ch_data, 64'h0);
    check("reset_busy", busy, 1'b0);
    pulse_cnt = 0;
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'h42, 8'd2);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h42, 8'd2);
    check("release_no_write", pulse_cnt, 0);

    // Basic write to channel 3.
    pulse_cnt = 0;
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'hA5, 8'd3);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 8'h00, 8'd0);
    check("basic_pulses", pulse_cnt, 1);
    check("basic_ch3", ch_data[3*W +: W], 8'hA5);
    check("basic_others", ch_data & ~(64'hFF << 24), 64'h0);

    // Invalid channel sets a sticky error.
    pulse_cnt = 0;
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 8'h11, 8'd9);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'h11, 8'd9);
    check("inv_pulses", pulse_cnt, 0);
    check("inv_data", ch_data, 64'hA5 << 24);
    check("inv_error", error, 1'b1);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 8'h5A, 8'd1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'h5A, 8'd1);
    check("inv_error_sticky", error, 1'b1);

    // Long strobe with data changing every cycle: only the third sample counts.
    pulse_cnt = 0;
    glitch_val = '0;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if (i == 2) glitch_val = d;
      cycle(1'b0, 1'b1, d, 8'd5);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'($urandom), 8'd5);
    check("glitch_pulses", pulse_cnt, 1);
    check("glitch_val", ch_data[5*W +: W], glitch_val);

    // Back-to-back writes to every channel.
    for (int i = 0; i < NF; i++) vals[i] = 8'(8'h10 * i + 8'h07 + i);
    for (int i = 0; i < NF; i++) begin
      cycle(1'b0, 1'b1, vals[i], 8'(i));
      cycle(1'b0, 1'b0, vals[i], 8'(i));
      cycle(1'b0, 1'b0, vals[i], 8'(i));
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00, 8'd0);
    for (int i = 0; i < NF; i++) check($sformatf("b2b_ch%0d", i), ch_data[i*W +: W], vals[i]);

    // Reset landing on the capture cycle drops the write.
    pulse_cnt = 0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h77, 8'd2);
    cycle(1'b1, 1'b1, 8'h77, 8'd2);
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", ch_valid, 8'h00);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'h77, 8'd2);
    check("midrst_pulses", pulse_cnt, 0);
    check("midrst_data", ch_data, 64'h0);

    // Broadcast select.
    pulse_cnt = 0;
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 8'h3C, 8'hFF);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'h3C, 8'hFF);
`ifdef INPUT_DEMUX_BROADCAST_EN
    check("bcast_data", ch_data, {8{8'h3C}});
    check("bcast_error", error, 1'b0);
    check("bcast_pulses", pulse_cnt, 1);
`else
    check("bcast_data", ch_data, 64'h0);
    check("bcast_error", error, 1'b1);
    check("bcast_pulses", pulse_cnt, 0);
`endif

    // Random strobe trains, selects and occasional resets.
    lvl = 1'b0;
    for (int it = 0; it < 300; it++) begin
      int r;
      lvl  = ~lvl;
      hold = $urandom_range(1, 6);
      r    = $urandom_range(0, 9);
      if (r < 7)       rsel = 8'($urandom_range(0, NF - 1));
      else if (r == 7) rsel = 8'hFF;
      else             rsel = 8'($urandom_range(NF, 254));
      for (int j = 0; j < hold; j++)
        cycle(($urandom_range(0, 60) == 0), lvl, 8'($urandom), rsel);
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 8'h00, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
